lfsr_rate_ctrl: RTL and testbench



---
 rtl/lfsr_rate_ctrl_pkg.sv | 16 +
 rtl/lfsr_rate_ctrl_core.sv | 27 ++
 rtl/lfsr_rate_ctrl.sv | 96 +++++++++
 tb/tb_lfsr_rate_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_rate_ctrl_pkg.sv
// Shared register map and CTRL bit positions for the LFSR rate controller.
package lfsr_rate_ctrl_pkg;

   typedef enum logic [1:0] {
      ADDR_VALUE = 2'd0,
      ADDR_CTRL  = 2'd1,
      ADDR_SEED  = 2'd2,
      ADDR_DIV   = 2'd3
   } reg_addr_e;

   localparam int CTRL_RUN  = 0;
   localparam int CTRL_STEP = 1;
   localparam int CTRL_LOAD = 2;
   localparam int CTRL_WRAP = 8;

endpackage

// File: rtl/lfsr_rate_ctrl_core.sv
// Fibonacci-style LFSR register: load beats advance, and a zero seed loads 1
// so the register can never lock up at all-zeros.
module lfsr_core #(
   parameter int               WIDTH = 5,
   parameter logic [WIDTH-1:0] TAPS  = 5'b10100
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             advance,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] lfsr,
   output logic [WIDTH-1:0] next_val
);

   assign next_val = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         lfsr <= WIDTH'(1);
      else if (load)
         lfsr <= (seed == '0) ? WIDTH'(1) : seed;
      else if (advance)
         lfsr <= next_val;
   end

endmodule

// File: rtl/lfsr_rate_ctrl.sv
// Avalon-MM register front end, rate divider and LOAD/STEP/tick priority
// around the LFSR core.
module lfsr_rate_ctrl
   import lfsr_rate_ctrl_pkg::*;
#(
   parameter int               WIDTH = 5,
   parameter logic [WIDTH-1:0] TAPS  = 5'b10100,
   parameter int               DIV_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             chipselect,
   input  logic [1:0]       address,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] lfsr_out,
   output logic             lfsr_tick
);

   logic [WIDTH-1:0] seed, seed_eff, next_val;
   logic [DIV_W-1:0] divider, div_cnt;
   logic             run, wrap;
   logic             ctrl_wr, seed_wr, div_wr;
   logic             step, load, div_hit, advance, wrap_set, wrap_clr;

   assign ctrl_wr  = chipselect && write && (address == ADDR_CTRL);
   assign seed_wr  = chipselect && write && (address == ADDR_SEED);
   assign div_wr   = chipselect && write && (address == ADDR_DIV);
   assign step     = ctrl_wr && writedata[CTRL_STEP];
   assign load     = ctrl_wr && writedata[CTRL_LOAD];
   assign wrap_clr = ctrl_wr && writedata[CTRL_WRAP];

   // STEP and a divider hit in the same cycle merge into one advance; LOAD wins.
   assign div_hit  = run && (div_cnt == divider);
   assign advance  = (step || div_hit) && !load;

   // Period end is judged against the value a LOAD would actually produce.
   assign seed_eff = (seed == '0) ? WIDTH'(1) : seed;
   assign wrap_set = advance && (next_val == seed_eff);

   lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
      .clk      (clk),
      .reset_n  (reset_n),
      .advance  (advance),
      .load     (load),
      .seed     (seed),
      .lfsr     (lfsr_out),
      .next_val (next_val)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seed    <= WIDTH'(1);
         divider <= '0;
         run     <= 1'b0;
      end else begin
         if (seed_wr) seed    <= writedata[WIDTH-1:0];
         if (div_wr)  divider <= writedata[DIV_W-1:0];
         if (ctrl_wr) run     <= writedata[CTRL_RUN];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         div_cnt <= '0;
      else if (load || div_wr || !run || div_hit)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DIV_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrap      <= 1'b0;
         lfsr_tick <= 1'b0;
      end else begin
         wrap      <= wrap_set || (wrap && !wrap_clr);
         lfsr_tick <= advance;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         readdata <= '0;
      else begin
         case (address)
            ADDR_VALUE: readdata <= 32'(lfsr_out);
            ADDR_CTRL:  readdata <= {23'b0, wrap, 6'b0, 1'b0, run};
            ADDR_SEED:  readdata <= 32'(seed);
            default:    readdata <= 32'(divider);
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_rate_ctrl.sv
// Directed bench for lfsr_rate_ctrl with a cycle-level reference model and
// hand-computed checkpoints from the register-level behaviour.
module tb_lfsr_rate_ctrl;

   localparam logic [4:0] TAPS = 5'b10100;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        chipselect = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        write = 1'b0;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [4:0]  lfsr_out;
   logic        lfsr_tick;

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   lfsr_rate_ctrl #(.WIDTH(5), .TAPS(5'b10100), .DIV_W(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .chipselect (chipselect),
      .address    (address),
      .write      (write),
      .writedata  (writedata),
      .readdata   (readdata),
      .lfsr_out   (lfsr_out),
      .lfsr_tick  (lfsr_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Next LFSR value as plain arithmetic: double, drop the overflow, add parity.
   function automatic logic [4:0] nxt(input logic [4:0] x);
      int p;
      p = $countones(x & TAPS) % 2;
      return 5'((int'(x) * 2 + p) % 32);
   endfunction

   // Reference model: m_rem counts down the cycles left until the next timed advance.
   logic [4:0]  m_lfsr, m_seed, m_se, m_nv;
   logic [31:0] m_div, m_rem, m_rd;
   bit          m_run, m_wrap, m_tick, m_ld, m_st, m_due, m_set, m_wctl, m_wdiv;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_lfsr = 5'd1; m_seed = 5'd1; m_div = 0; m_rem = 0;
         m_run = 0; m_wrap = 0; m_tick = 0; m_rd = 0;
      end else begin
         case (address)
            2'd0: m_rd = 32'(m_lfsr);
            2'd1: m_rd = (32'(m_wrap) << 8) | 32'(m_run);
            2'd2: m_rd = 32'(m_seed);
            default: m_rd = m_div;
         endcase
         m_wctl = chipselect && write && address == 2'd1;
         m_wdiv = chipselect && write && address == 2'd3;
         m_ld   = m_wctl && writedata[2];
         m_st   = m_wctl && writedata[1];
         m_due  = m_run && m_rem == 0;
         m_se   = (m_seed == 0) ? 5'd1 : m_seed;
         m_set  = 0;
         m_tick = 0;
         if (m_ld) m_lfsr = m_se;
         else if (m_st || m_due) begin
            m_nv = nxt(m_lfsr);
            m_lfsr = m_nv;
            m_tick = 1;
            m_set = (m_nv == m_se);
         end
         if (m_wdiv) m_rem = writedata;
         else if (m_ld || !m_run || m_due) m_rem = m_div;
         else m_rem = m_rem - 1;
         if (m_set) m_wrap = 1;
         else if (m_wctl && writedata[8]) m_wrap = 0;
         if (m_wctl) m_run = writedata[0];
         if (chipselect && write && address == 2'd2) m_seed = writedata[4:0];
         if (m_wdiv) m_div = writedata;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_lfsr", 32'(lfsr_out), 32'(m_lfsr));
         check("cyc_tick", 32'(lfsr_tick), 32'(m_tick));
         check("cyc_rdata", readdata, m_rd);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
      address = a;
      idle(1);
      check(name, readdata, exp);
   endtask

   // Returns cycles until the next tick, or -1 when the budget runs out.
   task automatic wait_tick(input int budget, output int cycles);
      cycles = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk); #1;
         if (lfsr_tick) begin cycles = i; break; end
      end
   endtask

   logic [4:0] step_seq [5];
   int cyc, last, nt;

   initial begin
      step_seq[0] = 5'h02; step_seq[1] = 5'h04; step_seq[2] = 5'h09;
      step_seq[3] = 5'h12; step_seq[4] = 5'h05;

      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      chk_en = 1'b1;

      // Reset values through the read port
      rd_check("rst_value", 2'd0, 32'd1);
      rd_check("rst_ctrl",  2'd1, 32'd0);
      rd_check("rst_seed",  2'd2, 32'd1);
      rd_check("rst_div",   2'd3, 32'd0);
      check("rst_tick", 32'(lfsr_tick), 32'd0);

      // Manual STEP writes
      for (int i = 0; i < 5; i++) begin
         wr(2'd1, 32'h2);
         check("step_lfsr", 32'(lfsr_out), 32'(step_seq[i]));
         check("step_tick", 32'(lfsr_tick), 32'd1);
      end
      rd_check("step_run0", 2'd1, 32'd0);

      // Free-running at DIVIDER=3 through one full period
      wr(2'd1, 32'h4);
      check("load_seed1", 32'(lfsr_out), 32'd1);
      wr(2'd3, 32'd3);
      wr(2'd1, 32'h1);
      address = 2'd1;
      cyc = 0; last = 0; nt = 0;
      while (nt < 31 && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         if (lfsr_tick) begin
            nt++;
            check("div3_gap", 32'(cyc - last), 32'd4);
            last = cyc;
         end
      end
      check("div3_ticks", 32'(nt), 32'd31);
      check("period_lfsr", 32'(lfsr_out), 32'd1);
      idle(1);
      check("wrap_set", readdata, 32'h101);
      wr(2'd1, 32'h101);
      idle(1);
      check("wrap_clr", readdata, 32'h1);

      // LOAD colliding with a timed advance
      wait_tick(10, cyc);
      check("sync_tick", 32'(cyc >= 0), 32'd1);
      wr(2'd2, 32'h12);
      idle(2);
      wr(2'd1, 32'h5);
      check("load_lfsr", 32'(lfsr_out), 32'h12);
      check("load_notick", 32'(lfsr_tick), 32'd0);
      wait_tick(10, cyc);
      check("load_gap", 32'(cyc), 32'd4);
      check("load_next", 32'(lfsr_out), 32'h05);

      // Zero seed guard and DIVIDER=0
      wr(2'd2, 32'h0);
      wr(2'd1, 32'h4);
      check("zero_load", 32'(lfsr_out), 32'd1);
      rd_check("zero_seed_rd", 2'd2, 32'd0);
      wr(2'd3, 32'd0);
      wr(2'd1, 32'h1);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         check("div0_nonzero", 32'(lfsr_out != 5'd0), 32'd1);
         check("div0_tick", 32'(lfsr_tick), 32'd1);
      end

      // Asynchronous reset pulse mid-cycle
      #1 reset_n = 1'b0;
      #1;
      check("arst_lfsr", 32'(lfsr_out), 32'd1);
      check("arst_rdata", readdata, 32'd0);
      check("arst_tick", 32'(lfsr_tick), 32'd0);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("post_rst_tick", 32'(lfsr_tick), 32'd0);
      end
      rd_check("post_rst_ctrl", 2'd1, 32'd0);
      rd_check("post_rst_seed", 2'd2, 32'd1);
      wr(2'd1, 32'h1);
      idle(1);
      check("rerun_tick", 32'(lfsr_tick), 32'd1);
      check("rerun_lfsr", 32'(lfsr_out), 32'h02);

      idle(2);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
